// File: rtl/prime_pkg.sv
// Shared types and constants for the prime range-sweep controller.
package prime_pkg;

    // Default candidate width; matches the prime detector's N input.
    localparam int unsigned PRIME_W = 32;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDone
    } sweep_state_t;

endpackage

// File: rtl/prime_fifo.sv
// Small synchronous FIFO holding primes found by the sweep.
// Supports push and pop in the same cycle, including when full.
// o_full_next gives the full flag that will be registered at the next edge,
// so the controller can register its issue-valid without a bubble.
module prime_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_full_next
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [AW:0]      w_count_nxt;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_data    = r_mem[r_rd_ptr];
    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    // Occupancy after this edge.
    always_comb begin
        w_count_nxt = r_count + (AW+1)'(w_push_ok) - (AW+1)'(w_pop_ok);
        o_full_next = (w_count_nxt == (AW+1)'(DEPTH));
    end

    // Storage, pointers and occupancy; reset clears everything including data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_nxt;
        end
    end

endmodule

// File: rtl/prime_sweep_ctrl.sv
// Range-sweep sequencer feeding the prime detector.
// Walks cur from lo to hi, issuing one candidate at a time over valid/ready,
// consumes the verdict, counts primes and buffers them in prime_fifo.
// Optional build macro PRIME_SWEEP_SKIP_EVEN_EN: even candidates other than 2
// are stepped over in ISSUE (one cycle each) without being issued.
module prime_sweep_ctrl
    import prime_pkg::*;
#(
    parameter int unsigned WIDTH      = PRIME_W,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_lo,
    input  logic [WIDTH-1:0] i_hi,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_cand_valid,
    input  logic             i_cand_ready,
    output logic [WIDTH-1:0] o_cand_n,
    input  logic             i_res_valid,
    input  logic             i_res_is_prime,
    output logic             o_prime_valid,
    input  logic             i_prime_ready,
    output logic [WIDTH-1:0] o_prime_n,
    output logic [WIDTH-1:0] o_prime_count
);

    sweep_state_t     r_state;
    sweep_state_t     w_state_nxt;
    logic [WIDTH-1:0] r_cur;
    logic [WIDTH-1:0] w_cur_nxt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_prime_count;
    logic             r_cand_valid;
    logic             r_busy;
    logic             r_done;
    logic             w_cand_valid_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_start_acc;
    logic             w_xfer;
    logic             w_verdict;
    logic             w_last;
    logic             w_skip;
    logic             w_skip_nxt;
    logic             w_push;
    logic             w_pop;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_fifo_full_nxt;

    assign w_start_acc = (r_state == StIdle) && i_start;
    // cand_valid is only ever high in ISSUE, so no state qualifier is needed.
    assign w_xfer      = r_cand_valid && i_cand_ready;
    assign w_verdict   = (r_state == StWait) && i_res_valid;
    // Equality before increment keeps hi = all-ones from wrapping cur.
    assign w_last      = (r_cur == r_hi);
    assign w_pop       = i_prime_ready && !w_fifo_empty;
    // Issue gating already guarantees space; the full check is a backstop.
    assign w_push      = w_verdict && i_res_is_prime && (!w_fifo_full || w_pop);

`ifdef PRIME_SWEEP_SKIP_EVEN_EN
    assign w_skip     = (r_state == StIssue) && !r_cur[0] && (r_cur != WIDTH'(2));
    assign w_skip_nxt = !w_cur_nxt[0] && (w_cur_nxt != WIDTH'(2));
`else
    assign w_skip     = 1'b0;
    assign w_skip_nxt = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_nxt = (i_lo > i_hi) ? StDone : StIssue;
                end
            end
            StIssue: begin
                if (w_skip) begin
                    w_state_nxt = w_last ? StDone : StIssue;
                end else if (w_xfer) begin
                    w_state_nxt = StWait;
                end
            end
            StWait: begin
                if (i_res_valid) begin
                    w_state_nxt = w_last ? StDone : StIssue;
                end
            end
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    // FSM outputs, computed one cycle ahead so the ports come straight from flops.
    always_comb begin
        w_cand_valid_nxt = (w_state_nxt == StIssue) && !w_fifo_full_nxt && !w_skip_nxt;
        w_busy_nxt       = (w_state_nxt != StIdle);
        w_done_nxt       = (w_state_nxt == StDone);
    end

    // Next candidate value.
    always_comb begin
        w_cur_nxt = r_cur;
        unique case (r_state)
            StIdle:  if (i_start) w_cur_nxt = i_lo;
            StIssue: if (w_skip && !w_last) w_cur_nxt = r_cur + WIDTH'(1);
            StWait:  if (i_res_valid && !w_last) w_cur_nxt = r_cur + WIDTH'(1);
            default: w_cur_nxt = r_cur;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cur         <= '0;
            r_hi          <= '0;
            r_prime_count <= '0;
            r_cand_valid  <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_cur        <= w_cur_nxt;
            r_cand_valid <= w_cand_valid_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            if (w_start_acc) begin
                r_hi          <= i_hi;
                r_prime_count <= '0;
            end else if (w_push && (r_prime_count != '1)) begin
                r_prime_count <= r_prime_count + WIDTH'(1);
            end
        end
    end

    prime_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (w_push),
        .i_data      (r_cur),
        .i_pop       (w_pop),
        .o_data      (o_prime_n),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_full_next (w_fifo_full_nxt)
    );

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_cand_valid  = r_cand_valid;
    assign o_cand_n      = r_cur;
    assign o_prime_valid = !w_fifo_empty;
    assign o_prime_count = r_prime_count;

endmodule

// File: doc/prime_sweep_ctrl.md
# prime_sweep_ctrl

Range-sweep sequencer that sits directly upstream of the prime-detect stage. It walks every candidate N from `lo` to `hi` and issues each one to the detector over a valid/ready handshake. It consumes the detector's `is_prime` verdict, counts the primes, and buffers each prime in a small output FIFO for downstream logging.

## Interface
- `WIDTH`, 32: candidate/bound/count width; matches the detector's N width.
- `FIFO_DEPTH`, 4: prime output FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  sweep request; sampled in IDLE only.
- `lo`  in  WIDTH  first candidate; captured on start accept.
- `hi`  in  WIDTH  last candidate, inclusive; captured on start accept.
- `busy`  out  1  high from the cycle after start accept until DONE exits.
- `done`  out  1  one-cycle pulse at sweep end.
- `cand_valid`  out  1  candidate offered to the detector.
- `cand_ready`  in  1  detector accepts the candidate.
- `cand_n`  out  WIDTH  candidate value; stable while `cand_valid` is high.
- `res_valid`  in  1  detector verdict strobe.
- `res_is_prime`  in  1  verdict for the outstanding candidate.
- `prime_valid`  out  1  FIFO not empty.
- `prime_ready`  in  1  downstream pops the FIFO head.
- `prime_n`  out  WIDTH  FIFO head value.
- `prime_count`  out  WIDTH  primes found in the current or last sweep.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - On `start`, capture `lo`/`hi`, set `cur=lo`, clear `prime_count`.
  - If `lo>hi`, go to DONE; otherwise go to ISSUE.
- ISSUE:
  - `cand_valid = (FIFO not full)`, `cand_n = cur`.
  - On `cand_valid && cand_ready`, go to WAIT.
- WAIT:
  - Exactly one candidate is outstanding; `cand_valid` is low.
  - On `res_valid`, if `res_is_prime`, push `cur` to the FIFO and increment `prime_count`.
  - Then, if `cur==hi`, go to DONE; else `cur=cur+1` and go to ISSUE.
- DONE: `done=1` for one cycle, then IDLE. The FIFO is not flushed, and `prime_count` holds its value.
- `start` while not in IDLE is ignored.
- `res_valid` outside WAIT is ignored.
- End detection uses equality before increment, so `hi = 2^WIDTH-1` never wraps `cur`.
- Push is guaranteed not to overflow, because ISSUE gates issue on FIFO space and only one candidate is ever outstanding.
- FIFO:
  - Push and pop may occur in the same cycle, including the cycle in which the FIFO is full.
  - `prime_valid`/`prime_n` reflect the registered head.
- `prime_count` saturates at `2^WIDTH-1`.

## Timing
- Reset values:
  - state IDLE; `busy=0`, `done=0`, `cand_valid=0`.
  - `cand_n=0`, `prime_valid=0`, `prime_n=0`, `prime_count=0`.
  - FIFO empty.
- Start accept at cycle T:
  - `busy` and `cand_valid` are high at T+1, provided the FIFO has space.
  - For `lo>hi`, `done` pulses at T+1.
- Handshake:
  - `cand_n`/`cand_valid` are registered.
  - Transfer occurs on the edge where both are high.
  - `cand_valid` never drops without a transfer, except when the FIFO is full in ISSUE before assertion.
- Verdict at edge R:
  - A pushed prime is visible on `prime_valid` at R+1.
  - The next `cand_valid` is high at R+1.
  - `done` pulses at R+1 if that verdict was the last candidate.
- Best-case throughput is one candidate per 2 cycles plus detector latency.
- Reset mid-sweep: immediate return to IDLE. The outstanding candidate is abandoned and the FIFO is cleared.

## Configuration
- `PRIME_SWEEP_SKIP_EVEN_EN`:
  - Defined: candidates that are even and ≠2 are not issued; the controller advances `cur` in ISSUE with no handshake, one cycle per skipped value, and these count as non-prime. End-of-range rules are unchanged; if `hi` is a skipped even, DONE follows the skip cycle.
  - Undefined: every value in `[lo,hi]` is issued.

## Structure
- Package `prime_pkg`:
  - State enum `sweep_state_t` (IDLE, ISSUE, WAIT, DONE).
  - `PRIME_W=32` default width constant.
- Sub-module `prime_fifo`: synchronous FIFO with `WIDTH`/`DEPTH` parameters, full/empty flags and same-cycle push/pop. The controller FSM and counter stay in `prime_sweep_ctrl`.

## Test plan
- Nominal sweep: bench detector with 1-cycle verdict, `prime_ready=1`; `lo=2, hi=13` → popped `prime_n` sequence is 2,3,5,7,11,13, `prime_count=6`, single `done` pulse.
- Empty range: `lo=10, hi=5`, start at T → `done` at T+1, no `cand_valid`, `prime_count=0`.
- Backpressure: `prime_ready=0`, `lo=2, hi=20` → the FIFO fills with 2,3,5,7 and `cand_valid` stays low with `cand_n` never exceeding 8; raise `prime_ready` → the sweep resumes and the total count is 8.
- Top of range: `lo=hi=32'hFFFFFFFF` → one candidate issued, `done`, `cur` never wraps to 0.
- Reset mid-sweep: assert `rst_n=0` in WAIT during `lo=2, hi=100` → all outputs return to reset values; a following start `lo=0, hi=1` gives `prime_count=0`.
- With `PRIME_SWEEP_SKIP_EVEN_EN` defined: `lo=2, hi=10` → issued candidates are 2,3,5,7,9, `prime_count=4`.
